// File: rtl/sha2_pad_multi.sv
// SHA-256/512 message padder: forwards FIFO words, then the 0x80 marker, zero fill and the length field.
// Latency: combinational pass-through, 0 cycles from FIFO to engine, with no internal buffering.
// Backpressure: fifo_rready follows shaf_rready; output word and state hold while valid && !ready.
module sha2_pad_multi #(
    parameter int DataW = 64,
    parameter int LenW  = 128
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sha_en,
    input  logic             mode_i,
    input  logic             hash_start,
    input  logic             hash_process,
    input  logic             hash_done,
    input  logic [LenW-1:0]  message_length,
    input  logic             fifo_rvalid,
    input  logic [DataW-1:0] fifo_rdata,
    input  logic [DataW/8-1:0] fifo_rmask,
    output logic             fifo_rready,
    output logic             shaf_rvalid,
    output logic [DataW-1:0] shaf_rdata,
    input  logic             shaf_rready,
    output logic             msg_feed_complete
);
    localparam int MW = DataW / 8;

    typedef enum logic [2:0] {
        StIdle, StRecv, StPad80, StPad00, StLenHi, StLenLo
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        word_idx_q;
    logic [LenW-1:0]   fed_bits_q;
    logic              mode_q;
    logic              proc_flag_q;

    logic              xfer, msg_word, clear_cnt, latch_mode, partial, mask_ok;
    logic [2:0]        nb;
    logic [5:0]        shift;
    logic [DataW-1:0]  aw_mask, keep64, marker64, keep_mask, marker, pad_word;
    logic [DataW-1:0]  len_hi, len_lo, word_dat;
    logic [MW-1:0]     act_mask, inv_mask;

    assign aw_mask  = mode_q ? {DataW{1'b1}} : DataW'(32'hFFFF_FFFF);
    assign act_mask = mode_q ? {MW{1'b1}} : MW'(4'hF);
    assign partial  = mode_q ? !(&fifo_rmask) : !(&fifo_rmask[3:0]);
    assign inv_mask = ~fifo_rmask & act_mask;
    assign mask_ok  = (inv_mask & (inv_mask + MW'(1))) == '0;

    // Marker position is computed on the 64-bit lane; SHA-256 takes the top half moved down.
    assign nb        = mode_q ? message_length[5:3] : {1'b0, message_length[4:3]};
    assign shift     = {nb, 3'b000};
    assign keep64    = ~({DataW{1'b1}} >> shift);
    assign marker64  = {1'b1, {(DataW-1){1'b0}}} >> shift;
    assign keep_mask = mode_q ? keep64 : (keep64 >> 32);
    assign marker    = mode_q ? marker64 : (marker64 >> 32);
    assign pad_word  = (fifo_rdata & keep_mask) | marker;

    assign len_hi = mode_q ? message_length[127:64] : DataW'(message_length[63:32]);
    assign len_lo = mode_q ? message_length[63:0]   : DataW'(message_length[31:0]);

    always_comb begin
        state_d     = state_q;
        shaf_rvalid = 1'b0;
        fifo_rready = 1'b0;
        word_dat    = '0;
        msg_word    = 1'b0;
        clear_cnt   = 1'b0;
        latch_mode  = 1'b0;
        if (!sha_en) begin
            state_d   = StIdle;
            clear_cnt = 1'b1;
        end else if (hash_start) begin
            state_d    = StRecv;
            clear_cnt  = 1'b1;
            latch_mode = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRecv: begin
                    if (fifo_rvalid && partial) begin
                        state_d = StPad80;
                    end else if (proc_flag_q && (fed_bits_q == message_length)) begin
                        state_d = StPad80;
                    end else begin
                        shaf_rvalid = fifo_rvalid;
                        fifo_rready = shaf_rready;
                        word_dat    = fifo_rdata;
                        msg_word    = 1'b1;
                    end
                end
                StPad80: begin
                    shaf_rvalid = 1'b1;
                    word_dat    = pad_word;
                    fifo_rready = shaf_rready && (nb != 3'd0);
                    if (shaf_rready) state_d = (word_idx_q == 4'd13) ? StLenHi : StPad00;
                end
                StPad00: begin
                    shaf_rvalid = 1'b1;
                    if (shaf_rready && (word_idx_q == 4'd13)) state_d = StLenHi;
                end
                StLenHi: begin
                    shaf_rvalid = 1'b1;
                    word_dat    = len_hi;
                    if (shaf_rready) state_d = StLenLo;
                end
                StLenLo: begin
                    shaf_rvalid = 1'b1;
                    word_dat    = len_lo;
                    if (shaf_rready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign xfer              = shaf_rvalid && shaf_rready;
    assign shaf_rdata        = shaf_rvalid ? (word_dat & aw_mask) : '0;
    assign msg_feed_complete = proc_flag_q && (state_q == StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            word_idx_q  <= '0;
            fed_bits_q  <= '0;
            mode_q      <= 1'b0;
            proc_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_mode) mode_q <= mode_i;
            if (clear_cnt) begin
                word_idx_q <= '0;
                fed_bits_q <= '0;
            end else if (xfer) begin
                word_idx_q <= word_idx_q + 4'd1;
                if (msg_word) fed_bits_q <= fed_bits_q + (mode_q ? LenW'(64) : LenW'(32));
            end
            if (hash_process) proc_flag_q <= 1'b1;
            else if (hash_done || hash_start) proc_flag_q <= 1'b0;
        end
    end

    a_partial_needs_proc: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StRecv && sha_en && !hash_start && fifo_rvalid && partial) |-> proc_flag_q);
    a_mask_contig: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (sha_en && !hash_start && fifo_rvalid && (state_q == StRecv || state_q == StPad80)) |-> mask_ok);
    a_block_multiple: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StLenLo && xfer) |-> (word_idx_q == 4'd15));
endmodule

// File: doc/sha2_pad_multi.md
Name: sha2_pad_multi

Overview:
- Multi-mode SHA-2 message padder between the message FIFO and the SHA-2 compression engine.
- Supports two modes, selected at run time and latched at hash_start:
  - SHA-256 family: 32-bit words, 512-bit block, 64-bit length field.
  - SHA-512 family: 64-bit words, 1024-bit block, 128-bit length field.
- Forwards message words, appends the 0x80 marker byte, zero fill and the big-endian length field.
- Tracks block position with a 4-bit word index; both modes use 16 words per block, with the length field in words 14 and 15.

Parameters:
- DataW, 64: datapath width. Must be 64. SHA-256 mode uses bits [31:0] only.
- LenW, 128: message_length width. Must be 128.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- sha_en  in  1  block enable; low forces idle
- mode_i  in  1  0 = SHA-256 family, 1 = SHA-512 family; sampled on hash_start
- hash_start  in  1  begin a new message
- hash_process  in  1  all message bytes have been written to the FIFO
- hash_done  in  1  digest finished; clears the process flag
- message_length  in  LenW  message length in bits, byte granular
- fifo_rvalid  in  1  FIFO word valid
- fifo_rdata  in  DataW  FIFO word, first byte in the MSBs of the active width
- fifo_rmask  in  DataW/8  byte-valid mask, contiguous from the MSB end
- fifo_rready  out  1  FIFO pop
- shaf_rvalid  out  1  word valid to the engine
- shaf_rdata  out  DataW  word to the engine
- shaf_rready  in  1  engine accepts the word
- msg_feed_complete  out  1  process flag set and state is StIdle

Behaviour:
- Reset:
  - State StIdle; word_idx 0; fed_bits 0; mode_q 0; proc_flag 0.
  - Outputs fifo_rready=0, shaf_rvalid=0, shaf_rdata=0, msg_feed_complete=0.
- Output gating: shaf_rdata is forced to 0 whenever shaf_rvalid=0. In SHA-256 mode shaf_rdata[63:32] is always 0.
- Active width AW is 32 or 64, from mode_q. Only the low AW/8 bits of fifo_rmask are examined. A word is partial when those bits are not all ones.
- Handshake:
  - A word transfers on shaf_rvalid && shaf_rready.
  - While valid && !ready, shaf_rdata and the state must not change.
  - fifo_rready is only ever asserted together with shaf_rready (combinational pass-through).
- proc_flag: set on hash_process; cleared on hash_done or hash_start; hash_process wins if coincident.
- Counters:
  - word_idx (4 bits) increments on every transfer and wraps 15 -> 0.
  - fed_bits (LenW) adds AW on every full message word transferred.
- States:
  - StIdle:
    - On sha_en && hash_start: latch mode_q, clear counters, go to StRecv.
  - StRecv:
    - fifo_rvalid && partial: no transfer; go to StPad80.
    - Else if !proc_flag: pass FIFO through; shaf_rvalid=fifo_rvalid, fifo_rready=shaf_rready.
    - Else if fed_bits == message_length: aligned end; go to StPad80.
    - Else: pass through as above.
  - StPad80:
    - shaf_rvalid=1.
    - nb = message_length[4:3] (SHA-256) or [5:3] (SHA-512).
    - Data = top nb bytes of fifo_rdata, then 0x80, then zeros.
    - fifo_rready = shaf_rready && nb != 0.
    - On transfer: go to StLenHi if word_idx == 13, else StPad00.
  - StPad00:
    - Emits 0.
    - On transfer: go to StLenHi if word_idx == 13, else stay.
    - Zero fill crosses a block boundary when the marker lands in word 14 or 15.
  - StLenHi:
    - Emits message_length[63:32] (SHA-256) or [127:64] (SHA-512).
    - On transfer: go to StLenLo.
  - StLenLo:
    - Emits message_length[31:0] or [63:0].
    - On transfer: go to StIdle; word_idx is then 0.
- Boundary conditions:
  - hash_start in any non-idle state: restart immediately. Counters cleared, mode relatched, next state StRecv. No transfer in that cycle: shaf_rvalid=0, fifo_rready=0.
  - sha_en low in any state: next state StIdle, counters cleared, no transfer.
  - mode_i changes after hash_start are ignored.
  - Reset mid-operation returns to the reset values above. No partial state survives.
  - An undefined state decodes to StIdle.
- Assertions:
  - Partial && fifo_rvalid implies proc_flag.
  - Mask is contiguous from the MSB end.
  - Total words emitted per message is a multiple of 16.

Test Plan:
- SHA-256 "abc": len=24, FIFO 0x61626300 with mask 4'b1110 -> 0x61626380, 13x 0, 0x00000000, 0x00000018. Exactly 16 words, one FIFO pop, msg_feed_complete=1 afterwards.
- SHA-512 "abc": FIFO 0x6162630000000000 with mask 8'hE0 -> 0x6162638000000000, 13x 0, LenHi 0, LenLo 0x18. 16 words.
- SHA-512 aligned, 14 full words, len=896 -> 14 data words, 0x8000000000000000 at idx 14, zeros at idx 15 and idx 0..13 of the next block, LenHi 0, LenLo 0x380. 32 words total.
- SHA-256 55 bytes, len=440 -> 13 full words, then partial 3 bytes at idx 13 as 0xXXXXXX80, then LenHi 0, LenLo 0x1B8. No Pad00, 16 words.
- Random shaf_rready backpressure (~50%) on all cases above -> identical word stream, shaf_rdata held stable while stalled, fifo_rready never high without shaf_rready.
- hash_start during StPad00 and rst_ni pulse during StLenHi -> both return to clean operation; a following "abc" run reproduces the first scenario exactly.
